// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: instruction fetch control.
// Owns the fetch PC and drives a single-outstanding instruction-memory port.
// Presents one instruction per response to decode, and accepts redirects and
// hazard holds back from decode. A 1-entry skid buffer catches a response
// that lands while decode is holding.
module ifu_fetch_ctrl #(
   parameter int unsigned          DataWidth = 32,
   parameter logic [DataWidth-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [DataWidth-1:0] NOP_INST  = 32'h0000_0013
) (
   input  logic                 brq_clk,
   input  logic                 brq_rst,
   // instruction memory port
   output logic                 imem_req,
   output logic [DataWidth-1:0] imem_addr,
   input  logic                 imem_gnt,
   input  logic                 imem_rvalid,
   input  logic [DataWidth-1:0] imem_rdata,
   // redirect and hazard controls from decode
   input  logic                 idu_flush,
   input  logic [1:0]           idu_next_pc_sel,
   input  logic [DataWidth-1:0] idu_branch_addr,
   input  logic [DataWidth-1:0] idu_jal_addr,
   input  logic [DataWidth-1:0] idu_jalr_addr,
   input  logic                 idu_hold,
   // fetched instruction to decode
   output logic [DataWidth-1:0] ifu_fetch_inst,
   output logic [DataWidth-1:0] ifu_pc,
   output logic                 ifu_stall
);

   typedef enum logic [2:0] {
      ST_IDLE,      // one cycle after reset before the first request
      ST_REQ,       // request asserted, waiting for grant
      ST_WAIT,      // granted, waiting for the response
      ST_IDLE_BUF,  // skid buffer full, no new request until it drains
      ST_DISCARD    // waiting for the response of a killed request
   } state_t;

   state_t               state;
   logic [DataWidth-1:0] fetch_pc;
   logic [DataWidth-1:0] req_pc;
   logic                 buf_valid;
   logic [DataWidth-1:0] buf_inst;
   logic [DataWidth-1:0] buf_pc;

   logic [DataWidth-1:0] sel_target;
   logic [DataWidth-1:0] redirect_pc;
   logic                 redirect;
   logic                 handshake;
   logic                 resp_live;

   // A flush with sel=00 is not a redirect and is ignored everywhere.
   assign redirect    = idu_flush && (idu_next_pc_sel != 2'b00);
   assign handshake   = (state == ST_REQ) && imem_gnt;
   // Responses only count while a live request is outstanding; a stale rvalid
   // left over from before a reset or a flush is dropped by state alone.
   assign resp_live   = (state == ST_WAIT) && imem_rvalid;
   assign redirect_pc = {sel_target[DataWidth-1:2], 2'b00};
   // fetch_pc is only ever loaded with word-aligned values, so it drives the
   // address pins directly and moves only on a grant or a redirect.
   assign imem_addr   = fetch_pc;

   // Redirect target select from the decode next-PC code.
   // NOTE: every always_comb output gets a value on every path (default first) so no latch is inferred.
   always_comb begin
      sel_target = idu_branch_addr;
      case (idu_next_pc_sel)
         2'b10:   sel_target = idu_jal_addr;
         2'b11:   sel_target = idu_jalr_addr;
         default: sel_target = idu_branch_addr;
      endcase
   end

   // Fetch FSM, skid buffer and registered decode-facing outputs.
   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge brq_clk or posedge brq_rst) begin
      if (brq_rst) begin
         state          <= ST_IDLE;
         fetch_pc       <= RESET_PC;
         req_pc         <= RESET_PC;
         imem_req       <= 1'b0;
         ifu_fetch_inst <= NOP_INST;
         ifu_pc         <= '0;
         ifu_stall      <= 1'b1;
         buf_valid      <= 1'b0;
         // NOTE: the buffer payload is reset too; only buf_valid is functional, but known contents keep waveforms clean.
         buf_inst       <= NOP_INST;
         buf_pc         <= '0;
      end else begin
         // Decode-facing outputs, in priority order.
         if (redirect) begin
            ifu_stall      <= 1'b1;
            ifu_fetch_inst <= NOP_INST;
            buf_valid      <= 1'b0;
         end else if (idu_hold) begin
            if (resp_live) begin
               buf_inst  <= imem_rdata;
               buf_pc    <= req_pc;
               buf_valid <= 1'b1;
            end
         end else if (buf_valid) begin
            ifu_fetch_inst <= buf_inst;
            ifu_pc         <= buf_pc;
            ifu_stall      <= 1'b0;
            buf_valid      <= 1'b0;
         end else if (resp_live) begin
            ifu_fetch_inst <= imem_rdata;
            ifu_pc         <= req_pc;
            ifu_stall      <= 1'b0;
         end else begin
            ifu_fetch_inst <= NOP_INST;
            ifu_stall      <= 1'b1;
         end

         // Request sequencing; imem_req is set together with each move into
         // or out of ST_REQ so the pin is a plain flop.
         case (state)
            ST_IDLE: begin
               if (redirect) fetch_pc <= redirect_pc;
               state    <= ST_REQ;
               imem_req <= 1'b1;
            end
            ST_REQ: begin
               if (handshake) begin
                  imem_req <= 1'b0;
                  if (redirect) begin
                     // The granted request is now stale; its response is dropped.
                     fetch_pc <= redirect_pc;
                     state    <= ST_DISCARD;
                  end else begin
                     req_pc   <= fetch_pc;
                     fetch_pc <= fetch_pc + DataWidth'(4);
                     state    <= ST_WAIT;
                  end
               end else if (redirect) begin
                  fetch_pc <= redirect_pc;
               end
            end
            ST_WAIT: begin
               if (redirect) begin
                  fetch_pc <= redirect_pc;
                  if (imem_rvalid) begin
                     state    <= ST_REQ;
                     imem_req <= 1'b1;
                  end else begin
                     state <= ST_DISCARD;
                  end
               end else if (imem_rvalid) begin
                  if (idu_hold || buf_valid) begin
                     state <= ST_IDLE_BUF;
                  end else begin
                     state    <= ST_REQ;
                     imem_req <= 1'b1;
                  end
               end
            end
            ST_IDLE_BUF: begin
               if (redirect) begin
                  fetch_pc <= redirect_pc;
                  state    <= ST_REQ;
                  imem_req <= 1'b1;
               end else if (!idu_hold) begin
                  // The buffer drains this cycle, so the next fetch can start.
                  state    <= ST_REQ;
                  imem_req <= 1'b1;
               end
            end
            ST_DISCARD: begin
               if (redirect) fetch_pc <= redirect_pc;
               if (imem_rvalid) begin
                  state    <= ST_REQ;
                  imem_req <= 1'b1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against a program-order fetch model.
module tb_ifu_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        brq_clk = 1'b0;
   logic        brq_rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        idu_flush;
   logic [1:0]  idu_next_pc_sel;
   logic [31:0] idu_branch_addr;
   logic [31:0] idu_jal_addr;
   logic [31:0] idu_jalr_addr;
   logic        idu_hold;
   logic [31:0] ifu_fetch_inst;
   logic [31:0] ifu_pc;
   logic        ifu_stall;

   int n_checks = 0;
   int n_pass   = 0;

   ifu_fetch_ctrl dut (
      .brq_clk         (brq_clk),
      .brq_rst         (brq_rst),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .idu_flush       (idu_flush),
      .idu_next_pc_sel (idu_next_pc_sel),
      .idu_branch_addr (idu_branch_addr),
      .idu_jal_addr    (idu_jal_addr),
      .idu_jalr_addr   (idu_jalr_addr),
      .idu_hold        (idu_hold),
      .ifu_fetch_inst  (ifu_fetch_inst),
      .ifu_pc          (ifu_pc),
      .ifu_stall       (ifu_stall)
   );

   always #5 brq_clk = ~brq_clk;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        flush;
      logic [1:0]  sel;
      logic [31:0] br;
      logic [31:0] jal;
      logic [31:0] jalr;
      logic        hold;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_stall;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   localparam int NV = 26;
   vec_t tv [NV];

   function automatic vec_t mk(int g, int rv, int rd, int fl, int s, int br, int jal,
                               int jalr, int h, int er, int ea, int es, int ep, int ei);
      vec_t v;
      v.gnt = g[0];      v.rvalid = rv[0];  v.rdata = rd;
      v.flush = fl[0];   v.sel = s[1:0];    v.br = br;
      v.jal = jal;       v.jalr = jalr;     v.hold = h[0];
      v.e_req = er[0];   v.e_addr = ea;     v.e_stall = es[0];
      v.e_pc = ep;       v.e_inst = ei;
      return v;
   endfunction

   // Instruction word the memory model returns for an address.
   function automatic logic [31:0] memf(logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge brq_clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      idu_flush = 1'b0; idu_next_pc_sel = 2'b00; idu_hold = 1'b0;
      idu_branch_addr = '0; idu_jal_addr = '0; idu_jalr_addr = '0;
   endtask

   task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_stall, input logic [31:0] e_pc, input logic [31:0] e_inst);
      check({tag, ".req"},   32'(imem_req),  32'(e_req));
      check({tag, ".addr"},  imem_addr,      e_addr);
      check({tag, ".stall"}, 32'(ifu_stall), 32'(e_stall));
      check({tag, ".pc"},    ifu_pc,         e_pc);
      check({tag, ".inst"},  ifu_fetch_inst, e_inst);
   endtask

   // Random-phase model state: the program-order PC the next delivered
   // instruction must carry, plus a one-outstanding memory responder.
   logic [31:0] exp_pc;
   logic        busy;
   int          lat;
   logic [31:0] pend_addr;
   logic        p_redirect, p_hold, p_req, p_gnt;
   logic [31:0] p_target, p_addr, s_pc, s_inst;
   logic        s_stall;
   int          quiet;

   initial begin
      brq_rst = 1'b1;
      idle_inputs();

      //            gnt rv rdata    fl s br            jal       jalr      h  req addr          st pc        inst
      tv[0]  = mk(1, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h000,      1, 32'h000,  NOP);
      tv[1]  = mk(1, 1, 32'h000, 0, 0, 0,           0,        0,        0, 0, 32'h004,      1, 32'h000,  NOP);
      tv[2]  = mk(1, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h004,      0, 32'h000,  32'h000);
      tv[3]  = mk(1, 1, 32'h004, 0, 0, 0,           0,        0,        0, 0, 32'h008,      1, 32'h000,  NOP);
      tv[4]  = mk(1, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h008,      0, 32'h004,  32'h004);
      tv[5]  = mk(1, 1, 32'h008, 0, 0, 0,           0,        0,        0, 0, 32'h00C,      1, 32'h004,  NOP);
      tv[6]  = mk(1, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h00C,      0, 32'h008,  32'h008);
      tv[7]  = mk(1, 1, 32'h00C, 0, 0, 0,           0,        0,        0, 0, 32'h010,      1, 32'h008,  NOP);
      tv[8]  = mk(1, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h010,      0, 32'h00C,  32'h00C);
      // jal redirect while waiting; the in-flight response must be dropped
      tv[9]  = mk(0, 0, 0,       1, 2, 32'h0800,    32'h100,  32'h0900, 0, 0, 32'h014,      1, 32'h00C,  NOP);
      tv[10] = mk(0, 1, 32'h010, 0, 0, 0,           0,        0,        0, 0, 32'h100,      1, 32'h00C,  NOP);
      tv[11] = mk(1, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h100,      1, 32'h00C,  NOP);
      tv[12] = mk(0, 1, 32'h100, 0, 0, 0,           0,        0,        0, 0, 32'h104,      1, 32'h00C,  NOP);
      tv[13] = mk(1, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h104,      0, 32'h100,  32'h100);
      // three-cycle hold with the response in the first held cycle
      tv[14] = mk(0, 1, 32'hDEAD,0, 0, 0,           0,        0,        1, 0, 32'h108,      1, 32'h100,  NOP);
      tv[15] = mk(0, 0, 0,       0, 0, 0,           0,        0,        1, 0, 32'h108,      1, 32'h100,  NOP);
      tv[16] = mk(0, 0, 0,       0, 0, 0,           0,        0,        1, 0, 32'h108,      1, 32'h100,  NOP);
      tv[17] = mk(0, 0, 0,       0, 0, 0,           0,        0,        0, 0, 32'h108,      1, 32'h100,  NOP);
      tv[18] = mk(1, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h108,      0, 32'h104,  32'hDEAD);
      tv[19] = mk(0, 0, 0,       0, 0, 0,           0,        0,        0, 0, 32'h10C,      1, 32'h104,  NOP);
      // buffer fills under hold, then flush+hold with jalr clears it
      tv[20] = mk(0, 1, 32'hBEEF,0, 0, 0,           0,        0,        1, 0, 32'h10C,      1, 32'h104,  NOP);
      tv[21] = mk(0, 0, 0,       1, 3, 32'h0700,    32'h0600, 32'h203,  1, 0, 32'h10C,      1, 32'h104,  NOP);
      tv[22] = mk(0, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h200,      1, 32'h104,  NOP);
      tv[23] = mk(1, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h200,      1, 32'h104,  NOP);
      tv[24] = mk(0, 1, 32'h200, 0, 0, 0,           0,        0,        0, 0, 32'h204,      1, 32'h104,  NOP);
      tv[25] = mk(0, 0, 0,       0, 0, 0,           0,        0,        0, 1, 32'h204,      0, 32'h200,  32'h200);

      // Reset values
      repeat (2) @(posedge brq_clk);
      #1;
      check_outs("reset", 1'b0, 32'h0, 1'b1, 32'h0, NOP);
      @(negedge brq_clk);
      brq_rst = 1'b0;

      // Directed vector table
      for (int i = 0; i < NV; i++) begin
         step();
         imem_gnt        = tv[i].gnt;
         imem_rvalid     = tv[i].rvalid;
         imem_rdata      = tv[i].rdata;
         idu_flush       = tv[i].flush;
         idu_next_pc_sel = tv[i].sel;
         idu_branch_addr = tv[i].br;
         idu_jal_addr    = tv[i].jal;
         idu_jalr_addr   = tv[i].jalr;
         idu_hold        = tv[i].hold;
         check_outs($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_stall,
                    tv[i].e_pc, tv[i].e_inst);
      end

      // Grant withheld at the top of the address space, then wrap
      idu_flush = 1'b1; idu_next_pc_sel = 2'b01; idu_branch_addr = 32'hFFFF_FFFF;
      imem_gnt = 1'b0;
      step();
      idle_inputs();
      check("wrap.redir_stall", 32'(ifu_stall), 1);
      for (int k = 0; k < 5; k++) begin
         check("nogrant.req", 32'(imem_req), 1);
         check("nogrant.addr", imem_addr, 32'hFFFF_FFFC);
         step();
      end
      check("nogrant.addr_final", imem_addr, 32'hFFFF_FFFC);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      check("wrap.addr", imem_addr, 32'h0000_0000);
      check("wrap.req", 32'(imem_req), 0);
      imem_rvalid = 1'b1; imem_rdata = 32'h1234;
      step();
      imem_rvalid = 1'b0;
      check("wrap.pc", ifu_pc, 32'hFFFF_FFFC);
      check("wrap.inst", ifu_fetch_inst, 32'h1234);
      check("wrap.stall", 32'(ifu_stall), 0);

      // Asynchronous reset in the middle of a transaction
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      check("pre_rst.wait_req", 32'(imem_req), 0);
      #2 brq_rst = 1'b1;
      #1;
      check_outs("async_rst", 1'b0, 32'h0, 1'b1, 32'h0, NOP);
      @(posedge brq_clk);
      @(negedge brq_clk);
      brq_rst = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h0BAD;
      step();
      check_outs("post_rst", 1'b1, 32'h0, 1'b1, 32'h0, NOP);
      step();
      imem_rvalid = 1'b0;
      check("stale.stall", 32'(ifu_stall), 1);
      check("stale.inst", ifu_fetch_inst, NOP);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h600D;
      step();
      imem_rvalid = 1'b0;
      check("first.pc", ifu_pc, 32'h0);
      check("first.inst", ifu_fetch_inst, 32'h600D);
      check("first.stall", 32'(ifu_stall), 0);

      // Randomized traffic against the program-order model
      brq_rst = 1'b1;
      idle_inputs();
      step();
      @(negedge brq_clk);
      brq_rst = 1'b0;
      exp_pc = 32'h0; busy = 1'b0; lat = 0; pend_addr = '0; quiet = 0;
      p_redirect = 1'b0; p_hold = 1'b0; p_req = 1'b0; p_gnt = 1'b0;
      p_target = '0; p_addr = '0; s_pc = '0; s_inst = '0; s_stall = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         step();
         // Scoreboard for the edge just taken
         if (p_redirect) begin
            check("rnd.redir_bubble", 32'(ifu_stall), 1);
            exp_pc = p_target;
            quiet  = 0;
         end else if (p_hold) begin
            check("rnd.hold_stall", 32'(ifu_stall), 32'(s_stall));
            check("rnd.hold_pc", ifu_pc, s_pc);
            check("rnd.hold_inst", ifu_fetch_inst, s_inst);
         end else if (!ifu_stall) begin
            check("rnd.pc", ifu_pc, exp_pc);
            check("rnd.inst", ifu_fetch_inst, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            quiet  = 0;
         end else begin
            quiet++;
         end
         if (quiet > 40) begin
            check("rnd.liveness_bubbles", quiet, 0);
            quiet = 0;
         end
         if (p_req && !p_gnt && !p_redirect) begin
            check("rnd.req_held", 32'(imem_req), 1);
            check("rnd.addr_held", imem_addr, p_addr);
         end
         if (imem_req) check("rnd.addr_align", 32'(imem_addr[1:0]), 0);
         // Memory responder: one response per grant, 1..3 cycles later
         if (p_req && p_gnt) begin
            check("rnd.one_outstanding", 32'(busy), 0);
            busy      = 1'b1;
            lat       = int'($urandom_range(1, 3));
            pend_addr = p_addr;
         end
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (busy) begin
            lat--;
            if (lat == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = memf(pend_addr);
               busy        = 1'b0;
            end
         end
         imem_gnt        = ($urandom_range(0, 9) < 7);
         idu_hold        = ($urandom_range(0, 9) < 2);
         idu_flush       = ($urandom_range(0, 15) == 0);
         idu_next_pc_sel = 2'($urandom_range(0, 3));
         idu_branch_addr = $urandom;
         idu_jal_addr    = $urandom;
         idu_jalr_addr   = $urandom;
         // Remember this cycle's inputs and outputs for the next edge
         p_redirect = idu_flush && (idu_next_pc_sel != 2'b00);
         case (idu_next_pc_sel)
            2'b01:   p_target = idu_branch_addr & 32'hFFFF_FFFC;
            2'b10:   p_target = idu_jal_addr & 32'hFFFF_FFFC;
            default: p_target = idu_jalr_addr & 32'hFFFF_FFFC;
         endcase
         p_hold  = idu_hold;
         p_req   = imem_req;
         p_gnt   = imem_gnt;
         p_addr  = imem_addr;
         s_stall = ifu_stall;
         s_pc    = ifu_pc;
         s_inst  = ifu_fetch_inst;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
